// File: rtl/pipe_rx_fifo_if.sv
// Valid/allowin handshake bundle for pipe_rx_fifo: upstream sink side, downstream
// source side, plus the occupancy and self-check observation outputs.
interface pipe_rx_fifo_if #(
   parameter int WIDTH = 100,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
);
   logic                       validin;
   logic [WIDTH-1:0]           datain;
   logic                       allowin;
   logic                       validout;
   logic [WIDTH-1:0]           dataout;
   logic                       out_allow;
   logic [$clog2(DEPTH):0]     level;
   logic [CNT_W-1:0]           accepted_cnt;
   logic [WIDTH-1:0]           checksum;

   // Slave is the FIFO itself; master is whatever drives it (pipeline + consumer).
   modport slave (
      input  validin, datain, out_allow,
      output allowin, validout, dataout, level, accepted_cnt, checksum
   );
   modport master (
      output validin, datain, out_allow,
      input  allowin, validout, dataout, level, accepted_cnt, checksum
   );
endinterface

// File: rtl/pipe_rx_fifo.sv
// Receive-side FWFT FIFO for the pipeline valid/allowin handshake, with an
// accepted-beat counter and running XOR checksum of everything pushed.
module pipe_rx_fifo #(
   parameter int WIDTH = 100,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   pipe_rx_fifo_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg;
   logic [LW-1:0]    level_reg, level_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] checksum_reg;
   logic             not_empty, not_full, push, pop;

   assign not_empty = (level_reg != '0);
   assign not_full  = (level_reg < LW'(DEPTH));

   // A pop in the same cycle frees a slot when full, so out_allow feeds allowin
   // combinationally just like the pipeline's own allowin chain.
   assign bus.allowin  = not_full || bus.out_allow;
   assign push         = bus.validin && bus.allowin;
   assign pop          = not_empty && bus.out_allow;

   assign bus.validout     = not_empty;
   assign bus.dataout      = not_empty ? mem[rd_ptr_reg] : '0;
   assign bus.level        = level_reg;
   assign bus.accepted_cnt = cnt_reg;
   assign bus.checksum     = checksum_reg;

   always_comb begin
      level_next = level_reg;
      unique case ({push, pop})
         2'b10:   level_next = level_reg + LW'(1);
         2'b01:   level_next = level_reg - LW'(1);
         default: level_next = level_reg;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         level_reg    <= '0;
         cnt_reg      <= '0;
         checksum_reg <= '0;
      end else begin
         level_reg <= level_next;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (push) begin
            wr_ptr_reg   <= wr_ptr_reg + AW'(1);
            cnt_reg      <= cnt_reg + CNT_W'(1);
            checksum_reg <= checksum_reg ^ bus.datain;
         end
      end
   end

   // Storage is never reset; level gates everything that could expose stale data.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= bus.datain;
   end
endmodule

// File: tb/tb_pipe_rx_fifo.sv
// Self-checking bench for pipe_rx_fifo: queue-based reference model checked every
// cycle, directed boundary scenarios, then randomized traffic.
module tb_pipe_rx_fifo;
   localparam int WIDTH  = 100;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 16;
   localparam int SCNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             vin = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic             oa  = 1'b0;

   always #5 clk = ~clk;

   pipe_rx_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W))  bus_a ();
   pipe_rx_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(SCNT_W)) bus_b ();

   assign bus_a.validin   = vin;
   assign bus_a.datain    = din;
   assign bus_a.out_allow = oa;
   assign bus_b.validin   = vin;
   assign bus_b.datain    = din;
   assign bus_b.out_allow = oa;

   pipe_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   pipe_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(SCNT_W)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: contents as a queue, counters as plain integers.
   logic [WIDTH-1:0] mq[$];
   int unsigned      m_cnt = 0;
   logic [WIDTH-1:0] m_cks = '0;
   logic [WIDTH-1:0] out_log[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_cnt = 0;
      m_cks = '0;
   endtask

   task automatic check_all();
      logic [WIDTH-1:0] exp_dout;
      exp_dout = (mq.size() != 0) ? mq[0] : '0;
      chk("validout",     128'(bus_a.validout), 128'(mq.size() != 0));
      chk("dataout",      128'(bus_a.dataout), 128'(exp_dout));
      chk("allowin",      128'(bus_a.allowin), 128'((mq.size() < DEPTH) || oa));
      chk("level",        128'(bus_a.level), 128'(mq.size()));
      chk("accepted_cnt", 128'(bus_a.accepted_cnt), 128'(m_cnt % (1 << CNT_W)));
      chk("checksum",     128'(bus_a.checksum), 128'(m_cks));
      chk("small_cnt",    128'(bus_b.accepted_cnt), 128'(m_cnt % (1 << SCNT_W)));
   endtask

   // One clock cycle: drive, check before the edge, advance the model after it.
   task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic a, output bit acc);
      bit do_push, do_pop;
      vin = v; din = d; oa = a;
      #1;
      check_all();
      do_push = v && ((mq.size() < DEPTH) || a);
      do_pop  = (mq.size() != 0) && a;
      if (do_pop)
         out_log.push_back(bus_a.dataout);
      $display("t=%0t vin=%0b din=%0h oa=%0b push=%0b pop=%0b dout=%0h level=%0d",
               $time, v, d, a, do_push, do_pop, bus_a.dataout, bus_a.level);
      @(posedge clk);
      if (do_pop)
         void'(mq.pop_front());
      if (do_push) begin
         mq.push_back(d);
         m_cnt++;
         m_cks = m_cks ^ d;
      end
      acc = do_push;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_clear();
      vin = 1'b0;
      oa  = 1'b0;
      @(negedge clk);
      check_all();
      rst = 1'b0;
   endtask

   initial begin
      bit acc;
      int idx;
      int guard;
      logic [127:0] rnd;

      // Reset state
      model_clear();
      @(negedge clk);
      check_all();
      chk("rst_allowin",  128'(bus_a.allowin), 128'(1));
      chk("rst_validout", 128'(bus_a.validout), 128'(0));
      chk("rst_level",    128'(bus_a.level), 128'(0));
      chk("rst_dataout",  128'(bus_a.dataout), 128'(0));
      chk("rst_cnt",      128'(bus_a.accepted_cnt), 128'(0));
      chk("rst_cks",      128'(bus_a.checksum), 128'(0));
      rst = 1'b0;

      // Fill with consumer stalled; fifth beat must bounce
      for (int i = 1; i <= 4; i++)
         cycle(1'b1, WIDTH'(i), 1'b0, acc);
      chk("full_level",   128'(bus_a.level), 128'(4));
      chk("full_allowin", 128'(bus_a.allowin), 128'(0));
      chk("full_cnt",     128'(bus_a.accepted_cnt), 128'(4));
      chk("full_cks",     128'(bus_a.checksum), 128'(4));
      chk("full_head",    128'(bus_a.dataout), 128'(1));
      cycle(1'b1, WIDTH'(5), 1'b0, acc);
      chk("full_reject",  128'(acc), 128'(0));
      chk("full_cnt2",    128'(bus_a.accepted_cnt), 128'(4));

      // Same-edge pop and push while full, then drain
      out_log.delete();
      cycle(1'b1, WIDTH'(5), 1'b1, acc);
      chk("pp_accept", 128'(acc), 128'(1));
      chk("pp_level",  128'(bus_a.level), 128'(4));
      chk("pp_head",   128'(bus_a.dataout), 128'(2));
      for (int i = 0; i < 4; i++)
         cycle(1'b0, '0, 1'b1, acc);
      chk("drain_len", 128'(out_log.size()), 128'(5));
      for (int i = 0; i < 5 && i < out_log.size(); i++)
         chk("drain_order", 128'(out_log[i]), 128'(i + 1));
      chk("drain_empty", 128'(bus_a.validout), 128'(0));

      // Empty FIFO has no bypass path
      vin = 1'b1; din = WIDTH'(10); oa = 1'b1;
      #1;
      chk("nobypass_valid", 128'(bus_a.validout), 128'(0));
      cycle(1'b1, WIDTH'(10), 1'b1, acc);
      chk("fwft_valid", 128'(bus_a.validout), 128'(1));
      chk("fwft_data",  128'(bus_a.dataout), 128'(10));
      cycle(1'b0, '0, 1'b1, acc);
      chk("fwft_level", 128'(bus_a.level), 128'(0));

      // Streaming 1..20 with toggling consumer
      do_reset();
      out_log.delete();
      idx = 1;
      guard = 0;
      while (idx <= 20 && guard < 200) begin
         cycle(1'b1, WIDTH'(idx), guard[0] == 1'b0, acc);
         if (acc) idx++;
         guard++;
      end
      guard = 0;
      while (bus_a.validout && guard < 50) begin
         cycle(1'b0, '0, 1'b1, acc);
         guard++;
      end
      chk("stream_done", 128'(idx), 128'(21));
      chk("stream_len",  128'(out_log.size()), 128'(20));
      for (int i = 0; i < 20 && i < out_log.size(); i++)
         chk("stream_order", 128'(out_log[i]), 128'(i + 1));
      chk("stream_cnt", 128'(bus_a.accepted_cnt), 128'(20));
      chk("stream_cks", 128'(bus_a.checksum), 128'(20));

      // Narrow counter wraps after 17 pushes
      do_reset();
      for (int i = 0; i < 17; i++)
         cycle(1'b1, WIDTH'(i + 100), 1'b1, acc);
      chk("wrap_small_cnt", 128'(bus_b.accepted_cnt), 128'(1));
      chk("wrap_big_cnt",   128'(bus_a.accepted_cnt), 128'(17));

      // Asynchronous reset mid-cycle with three beats held
      do_reset();
      for (int i = 1; i <= 3; i++)
         cycle(1'b1, WIDTH'(i * 7), 1'b0, acc);
      chk("ar_level_pre", 128'(bus_a.level), 128'(3));
      vin = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("ar_level",    128'(bus_a.level), 128'(0));
      chk("ar_validout", 128'(bus_a.validout), 128'(0));
      chk("ar_dataout",  128'(bus_a.dataout), 128'(0));
      chk("ar_allowin",  128'(bus_a.allowin), 128'(1));
      chk("ar_cnt",      128'(bus_a.accepted_cnt), 128'(0));
      chk("ar_cks",      128'(bus_a.checksum), 128'(0));
      chk("ar_small",    128'(bus_b.accepted_cnt), 128'(0));
      model_clear();
      @(negedge clk);
      rst = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
         cycle($urandom_range(0, 3) != 0, rnd[WIDTH-1:0], $urandom_range(0, 4) < 3, acc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
